mapu_arb: RTL and testbench

- Round-robin arbiter and sequencer sharing one Matrix APU (mapu_top) between NUM_REQ requesters.
- Sits between requester ports and the MAPU control/data planes.
- Grants one requester per operation, drives MAPU enable/opcode, forwards that requester's two operand beats, and routes the single result beat (with overflow flag) back to it.
- Provides a response watchdog.

---
 rtl/mapu_arb.sv | 171 +++++++++++++++++
 tb/tb_mapu_arb.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mapu_arb.sv
// Round-robin arbiter/sequencer sharing one MAPU between NUM_REQ requesters.
// Each grant forwards two operand beats, returns one result beat, and runs a sticky watchdog.
module mapu_arb_lane (
    input  logic gnt,
    input  logic fwd,
    input  logic rsp,
    input  logic m_rdy,
    input  logic m_rsp_vld,
    output logic req_rdy,
    output logic rsp_vld
);
    assign req_rdy = gnt & fwd & m_rdy;
    assign rsp_vld = gnt & rsp & m_rsp_vld;
endmodule

module mapu_arb #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int OP_W    = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_vld,
    input  logic [NUM_REQ*OP_W-1:0]   req_op,
    input  logic [NUM_REQ*DATA_W-1:0] req_r0,
    input  logic [NUM_REQ*DATA_W-1:0] req_r1,
    input  logic [NUM_REQ*DATA_W-1:0] req_r2,
    output logic [NUM_REQ-1:0]        req_rdy,
    output logic [NUM_REQ-1:0]        rsp_vld,
    output logic [DATA_W-1:0]         rsp_r0,
    output logic [DATA_W-1:0]         rsp_r1,
    output logic [DATA_W-1:0]         rsp_r2,
    output logic                      rsp_of,
    input  logic [NUM_REQ-1:0]        rsp_rdy,
    output logic                      m_en,
    output logic [OP_W-1:0]           m_op,
    output logic                      m_vld,
    output logic [DATA_W-1:0]         m_r0,
    output logic [DATA_W-1:0]         m_r1,
    output logic [DATA_W-1:0]         m_r2,
    input  logic                      m_rdy,
    input  logic                      m_rsp_vld,
    input  logic [DATA_W-1:0]         m_rsp_r0,
    input  logic [DATA_W-1:0]         m_rsp_r1,
    input  logic [DATA_W-1:0]         m_rsp_r2,
    input  logic                      m_of,
    output logic                      m_rsp_rdy,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      timeout,
    input  logic                      clr_timeout
);
    localparam int IW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int IW1 = IW + 1;
    localparam int CW  = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  TO_MAX = CW'(TIMEOUT);
    localparam logic [CW-1:0]  TO_HIT = CW'(TIMEOUT - 1);
    localparam logic [IW-1:0]  LAST   = IW'(NUM_REQ - 1);
    localparam logic [IW1-1:0] NREQ   = IW1'(NUM_REQ);

    typedef enum logic [1:0] {IDLE, OP_A, OP_B, WAIT_RSP} state_t;

    state_t         state, state_nxt;
    logic [IW-1:0]  rr, gidx, pick_idx;
    logic [IW1-1:0] pick_pos;
    logic           pick_vld, fwd, rsp_ph, op_hs, rsp_hs, wd_hit;
    logic [CW-1:0]  wd_cnt;

    // First requester at or after rr, wrapping modulo NUM_REQ.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        pick_pos = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pick_pos = {1'b0, rr} + IW1'(k);
            if (pick_pos >= NREQ) pick_pos = pick_pos - NREQ;
            if (!pick_vld && req_vld[pick_pos[IW-1:0]]) begin
                pick_vld = 1'b1;
                pick_idx = pick_pos[IW-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (pick_vld) state_nxt = OP_A;
            OP_A:     if (op_hs)    state_nxt = OP_B;
            OP_B:     if (op_hs)    state_nxt = WAIT_RSP;
            WAIT_RSP: if (rsp_hs)   state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_comb begin
        fwd    = 1'b0;
        rsp_ph = 1'b0;
        case (state)
            OP_A, OP_B: fwd    = 1'b1;
            WAIT_RSP:   rsp_ph = 1'b1;
            default:    ;
        endcase
        m_vld     = fwd && req_vld[gidx];
        m_rsp_rdy = rsp_ph && rsp_rdy[gidx];
    end

    assign op_hs  = m_vld && m_rdy;
    assign rsp_hs = m_rsp_vld && m_rsp_rdy;

    assign m_r0   = req_r0[gidx*DATA_W +: DATA_W];
    assign m_r1   = req_r1[gidx*DATA_W +: DATA_W];
    assign m_r2   = req_r2[gidx*DATA_W +: DATA_W];
    assign rsp_r0 = m_rsp_r0;
    assign rsp_r1 = m_rsp_r1;
    assign rsp_r2 = m_rsp_r2;
    assign rsp_of = m_of;

    // Grant and opcode are captured once in IDLE and held until the result handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt  <= '0;
            gidx <= '0;
            rr   <= '0;
            m_en <= 1'b0;
            m_op <= '0;
        end else if (state == IDLE && pick_vld) begin
            gnt  <= NUM_REQ'(1) << pick_idx;
            gidx <= pick_idx;
            m_en <= 1'b1;
            m_op <= req_op[pick_idx*OP_W +: OP_W];
        end else if (rsp_ph && rsp_hs) begin
            gnt  <= '0;
            m_en <= 1'b0;
            rr   <= (gidx == LAST) ? '0 : gidx + 1'b1;
        end
    end

    // Count saturates so the flag fires once per stalled response; a new expiry beats clr.
    assign wd_hit = rsp_ph && !rsp_hs && (wd_cnt == TO_HIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_cnt  <= '0;
            timeout <= 1'b0;
        end else begin
            if (state == OP_B && op_hs)
                wd_cnt <= '0;
            else if (rsp_ph && !rsp_hs && wd_cnt != TO_MAX)
                wd_cnt <= wd_cnt + 1'b1;
            if (wd_hit)           timeout <= 1'b1;
            else if (clr_timeout) timeout <= 1'b0;
        end
    end

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
        mapu_arb_lane u_lane (
            .gnt       (gnt[i]),
            .fwd       (fwd),
            .rsp       (rsp_ph),
            .m_rdy     (m_rdy),
            .m_rsp_vld (m_rsp_vld),
            .req_rdy   (req_rdy[i]),
            .rsp_vld   (rsp_vld[i])
        );
    end
endmodule

// File: tb/tb_mapu_arb.sv
// Directed bench for mapu_arb: bench plays requesters and a MAPU model, results checked via a scoreboard.
module tb_mapu_arb;
    localparam int NR = 4;
    localparam int DW = 32;
    localparam int OW = 2;
    localparam int TO = 16;

    typedef struct packed { logic [DW-1:0] r0, r1, r2; } beat_t;
    typedef struct packed { logic [NR-1:0] vld; logic [DW-1:0] r0, r1, r2; logic of; } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic [NR-1:0]    req_vld, req_rdy, rsp_vld, rsp_rdy, gnt;
    logic [NR*OW-1:0] req_op;
    logic [NR*DW-1:0] req_r0, req_r1, req_r2;
    logic [DW-1:0]    rsp_r0, rsp_r1, rsp_r2, m_r0, m_r1, m_r2, m_rsp_r0, m_rsp_r1, m_rsp_r2;
    logic             rsp_of, m_en, m_vld, m_rdy, m_rsp_vld, m_of, m_rsp_rdy, timeout, clr_timeout;
    logic [OW-1:0]    m_op;

    logic [OW-1:0] ops [NR];
    exp_t sbq[$];
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mapu_arb #(.NUM_REQ(NR), .DATA_W(DW), .OP_W(OW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .req_vld(req_vld), .req_op(req_op), .req_r0(req_r0), .req_r1(req_r1), .req_r2(req_r2),
        .req_rdy(req_rdy), .rsp_vld(rsp_vld), .rsp_r0(rsp_r0), .rsp_r1(rsp_r1), .rsp_r2(rsp_r2),
        .rsp_of(rsp_of), .rsp_rdy(rsp_rdy),
        .m_en(m_en), .m_op(m_op), .m_vld(m_vld), .m_r0(m_r0), .m_r1(m_r1), .m_r2(m_r2),
        .m_rdy(m_rdy), .m_rsp_vld(m_rsp_vld), .m_rsp_r0(m_rsp_r0), .m_rsp_r1(m_rsp_r1),
        .m_rsp_r2(m_rsp_r2), .m_of(m_of), .m_rsp_rdy(m_rsp_rdy),
        .gnt(gnt), .timeout(timeout), .clr_timeout(clr_timeout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic beat_t rnd_beat();
        rnd_beat = {$urandom, $urandom, $urandom};
    endfunction

    task automatic set_beat(input int idx, input beat_t b);
        req_r0[idx*DW +: DW] = b.r0;
        req_r1[idx*DW +: DW] = b.r1;
        req_r2[idx*DW +: DW] = b.r2;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_gnt"},     32'(gnt), 0);
        chk({tag, "_m_en"},    32'(m_en), 0);
        chk({tag, "_m_op"},    32'(m_op), 0);
        chk({tag, "_req_rdy"}, 32'(req_rdy), 0);
        chk({tag, "_rsp_vld"}, 32'(rsp_vld), 0);
        chk({tag, "_m_rsp_rdy"}, 32'(m_rsp_rdy), 0);
        chk({tag, "_m_vld"},   32'(m_vld), 0);
        chk({tag, "_timeout"}, 32'(timeout), 0);
    endtask

    // One full grant for requester idx; called at an IDLE negedge with req_vld already set.
    task automatic serve(input int idx, input int stall_b, input int rsp_wait, input int rdy_hold,
                         input logic of, input logic op_chg, input logic chk_to);
        beat_t a, b, ga, gb;
        exp_t  e;
        int    n;
        a = rnd_beat();
        b = rnd_beat();
        set_beat(idx, a);
        e.vld = NR'(1 << idx);
        e.r0  = a.r0 + b.r0;
        e.r1  = a.r1 ^ b.r1;
        e.r2  = a.r2 - b.r2;
        e.of  = of;
        sbq.push_back(e);
        n = 0;
        do begin @(negedge clk); n++; end while (gnt == '0 && n < 20);
        chk("gnt_latency", 32'(n), 1);
        chk("gnt", 32'(gnt), 32'(1 << idx));
        chk("m_en", 32'(m_en), 1);
        chk("m_op", 32'(m_op), 32'(ops[idx]));
        m_rdy = 1'b1;
        #1;
        chk("m_vld_a", 32'(m_vld), 1);
        chk("req_rdy_a", 32'(req_rdy), 32'(1 << idx));
        ga = {m_r0, m_r1, m_r2};
        @(negedge clk);
        set_beat(idx, b);
        m_rdy = 1'b0;
        for (int s = 0; s < stall_b; s++) begin
            if (op_chg && s == 0) req_op[idx*OW +: OW] = ~ops[idx];
            #1;
            chk("m_vld_stall", 32'(m_vld), 1);
            chk("m_r1_stall", m_r1, b.r1);
            chk("req_rdy_stall", 32'(req_rdy), 0);
            chk("m_op_hold", 32'(m_op), 32'(ops[idx]));
            @(negedge clk);
        end
        m_rdy = 1'b1;
        #1;
        chk("m_vld_b", 32'(m_vld), 1);
        chk("req_rdy_b", 32'(req_rdy), 32'(1 << idx));
        gb = {m_r0, m_r1, m_r2};
        @(negedge clk);
        m_rdy    = 1'b0;
        m_rsp_r0 = ga.r0 + gb.r0;
        m_rsp_r1 = ga.r1 ^ gb.r1;
        m_rsp_r2 = ga.r2 - gb.r2;
        m_of     = of;
        for (int j = 1; j <= rsp_wait; j++) begin
            #1;
            chk("m_vld_wait", 32'(m_vld), 0);
            chk("rsp_vld_wait", 32'(rsp_vld), 0);
            chk("m_rsp_rdy_wait", 32'(m_rsp_rdy), 1);
            if (chk_to && j == TO)     chk("timeout_pre", 32'(timeout), 0);
            if (chk_to && j == TO + 1) chk("timeout_set", 32'(timeout), 1);
            @(negedge clk);
        end
        m_rsp_vld    = 1'b1;
        rsp_rdy[idx] = 1'b0;
        for (int h = 0; h < rdy_hold; h++) begin
            #1;
            chk("m_rsp_rdy_hold", 32'(m_rsp_rdy), 0);
            chk("rsp_vld_hold", 32'(rsp_vld), 32'(1 << idx));
            chk("rsp_of_hold", 32'(rsp_of), 32'(of));
            @(negedge clk);
        end
        rsp_rdy[idx] = 1'b1;
        #1;
        chk("m_rsp_rdy", 32'(m_rsp_rdy), 1);
        if (rsp_vld != '0 && sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("rsp_vld", 32'(rsp_vld), 32'(e.vld));
            chk("rsp_r0", rsp_r0, e.r0);
            chk("rsp_r1", rsp_r1, e.r1);
            chk("rsp_r2", rsp_r2, e.r2);
            chk("rsp_of", 32'(rsp_of), 32'(e.of));
        end else begin
            chk("rsp_present", 32'(rsp_vld), 32'(1 << idx));
        end
        @(negedge clk);
        m_rsp_vld = 1'b0;
        #1;
        chk("gnt_clr", 32'(gnt), 0);
        chk("m_en_clr", 32'(m_en), 0);
    endtask

    initial begin
        ops[0] = 2'd2; ops[1] = 2'd3; ops[2] = 2'd1; ops[3] = 2'd2;
        reset = 1'b1;
        req_vld = '0; req_op = {ops[3], ops[2], ops[1], ops[0]};
        req_r0 = '0; req_r1 = '0; req_r2 = '0; rsp_rdy = '1;
        m_rdy = 1'b0; m_rsp_vld = 1'b0; m_of = 1'b0; clr_timeout = 1'b0;
        m_rsp_r0 = '0; m_rsp_r1 = '0; m_rsp_r2 = '0;
        repeat (2) @(negedge clk);
        #1;
        chk_quiet("reset");
        reset = 1'b0;

        // Lone requester 2, then {0,3} pending: rr=3 must pick 3 first.
        req_vld = 4'b0100;
        serve(2, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        req_vld = 4'b1001;
        serve(3, 0, 1, 0, 1'b0, 1'b0, 1'b0);

        // Everyone requesting continuously: strict rotation twice round.
        req_vld = 4'b1111;
        for (int t = 0; t < 8; t++) serve(t % NR, t % 2, t % 3, 0, 1'(t % 2), 1'b0, 1'b0);

        // Operand stall in OP_B with the opcode input changed mid-grant.
        req_vld = 4'b0010;
        serve(1, 5, 1, 0, 1'b0, 1'b1, 1'b0);
        req_op = {ops[3], ops[2], ops[1], ops[0]};

        // Withheld result trips the watchdog; the transaction still completes.
        req_vld = 4'b0100;
        serve(2, 0, 20, 0, 1'b0, 1'b0, 1'b1);
        req_vld = '0;
        #1;
        chk("timeout_sticky", 32'(timeout), 1);
        clr_timeout = 1'b1;
        @(negedge clk);
        clr_timeout = 1'b0;
        #1;
        chk("timeout_clr", 32'(timeout), 0);

        // Requester back-pressure on the result with overflow set (rr=3 wraps to 0).
        req_vld = 4'b0001;
        serve(0, 0, 0, 3, 1'b1, 1'b0, 1'b0);

        // Reset in OP_B aborts the grant; the next grant restarts at requester 0.
        req_vld = 4'b0100;
        set_beat(2, rnd_beat());
        @(negedge clk);
        #1;
        chk("rst_gnt", 32'(gnt), 32'h4);
        m_rdy = 1'b1;
        @(negedge clk);
        m_rdy = 1'b0;
        #1;
        chk("rst_in_op_b", 32'(m_vld), 1);
        reset = 1'b1;
        #1;
        chk_quiet("midreset");
        @(negedge clk);
        reset   = 1'b0;
        req_vld = 4'b1111;
        serve(0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        req_vld = '0;

        chk("sb_empty", 32'(sbq.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
